// File: rtl/vector_scanner_pkg.sv
// Shared types and helpers for the vector scanner family.
//   state_e    : scanner control state (IDLE, SCAN)
//   pos_width  : width of a position field able to encode the value WIDTH
//   none_pos   : position code reported for an all-zero vector (equals WIDTH)
package vector_detector_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic int pos_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int none_pos(input int width);
        return width;
    endfunction

endpackage

// File: rtl/vector_scanner_if.sv
// Handshake bundle between a vector producer / hit consumer and the scanner.
//   in_valid/in_ready/data_in/dir_in/all_in : vector request channel
//   out_valid/out_ready/pos_out/last_out/none_out : hit result channel
//   master modport : the producer/consumer side
//   slave modport  : the scanner side
interface vector_scanner_if
    import vector_detector_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int POS_W = pos_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             dir_in;
    logic             all_in;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] pos_out;
    logic             last_out;
    logic             none_out;

    modport master (
        output in_valid, data_in, dir_in, all_in, out_ready,
        input  in_ready, out_valid, pos_out, last_out, none_out
    );

    modport slave (
        input  in_valid, data_in, dir_in, all_in, out_ready,
        output in_ready, out_valid, pos_out, last_out, none_out
    );

endinterface

// File: rtl/vector_scanner_lead_one_enc.sv
// Combinational leading-one encoder built as a log2-depth binary tree.
//   vec      : input vector, bit WIDTH-1 has highest priority
//   position : index of the leading one counted from the MSB (MSB = 0)
//   any      : at least one bit of vec is set
// Non-power-of-two widths are padded with zeros below the LSB, so the
// padding can never win the priority race.
module lead_one_enc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] position,
    output logic                     any
);
    localparam int L   = $clog2(WIDTH);
    localparam int P   = 1 << L;
    localparam int PAD = P - WIDTH;

    logic [P-1:0]   padded;
    // Heap-ordered tree: node 1 is the root, node n has children 2n and 2n+1,
    // leaves occupy nodes P..2P-1 in MSB-first order.
    logic [2*P-1:1] any_t;
    logic [L-1:0]   pos_t [1:2*P-1];

    assign padded = P'(vec) << PAD;

    for (genvar j = 0; j < P; j++) begin : g_leaf
        assign any_t[P+j] = padded[P-1-j];
        assign pos_t[P+j] = '0;
    end

    for (genvar n = 1; n < P; n++) begin : g_node
        // Height of this node above the leaves; it decides which pos bit
        // distinguishes its left (higher priority) and right subtrees.
        localparam int           H   = L - $clog2(n + 1) + 1;
        localparam logic [L-1:0] SEL = L'(1) << (H - 1);

        assign any_t[n] = any_t[2*n] | any_t[2*n+1];
        assign pos_t[n] = any_t[2*n] ? pos_t[2*n] : (pos_t[2*n+1] | SEL);
    end

    assign position = pos_t[1];
    assign any      = any_t[1];

endmodule

// File: rtl/vector_scanner.sv
// Handshaked set-bit scanner: accepts one WIDTH-bit vector per transaction
// and emits the positions of its set bits one beat at a time.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of vector_scanner_if (request and result channels)
// The residual register is always held MSB-first; LSB-first scans are
// bit-reversed on accept so one encoder serves both directions.
module vector_scanner
    import vector_detector_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    vector_scanner_if.slave  bus
);
    localparam int               POS_W   = pos_width(WIDTH);
    localparam int               ENC_W   = POS_W - 1;
    localparam logic [POS_W-1:0] NONE    = POS_W'(none_pos(WIDTH));
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state, state_d;
    logic [WIDTH-1:0] residual, residual_d;
    logic             all_q, all_d;

    logic [WIDTH-1:0] data_rev;
    logic [ENC_W-1:0] enc_pos;
    logic             enc_any;
    logic             out_valid;
    logic             single_bit;
    logic             last_raw;
    logic             beat;
    logic             final_beat;
    logic             accept;

    lead_one_enc #(.WIDTH(WIDTH)) u_enc (
        .vec      (residual),
        .position (enc_pos),
        .any      (enc_any)
    );

    always_comb begin
        data_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            data_rev[i] = bus.data_in[WIDTH-1-i];
        end
    end

    // True for zero or exactly one set bit: either way this beat is the last.
    assign single_bit = (residual & (residual - 1'b1)) == '0;
    assign last_raw   = !all_q || single_bit;

    assign out_valid  = (state == SCAN);
    assign beat       = out_valid && bus.out_ready;
    assign final_beat = beat && last_raw;
    assign accept     = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = (state == IDLE) || final_beat;
    assign bus.out_valid = out_valid;
    assign bus.pos_out   = !out_valid ? '0 : (enc_any ? {1'b0, enc_pos} : NONE);
    assign bus.last_out  = out_valid && last_raw;
    assign bus.none_out  = out_valid && !enc_any;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state;
        residual_d = residual;
        all_d      = all_q;

        if (beat && !last_raw) begin
            // Knock out the reported hit; the encoder then finds the next one.
            residual_d = residual & ~(MSB_ONE >> enc_pos);
        end
        if (final_beat) begin
            state_d = IDLE;
        end
        // A new accept overrides the final-beat return to IDLE: no bubble.
        if (accept) begin
            state_d    = SCAN;
            residual_d = bus.dir_in ? data_rev : bus.data_in;
            all_d      = bus.all_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            residual <= '0;
            all_q    <= 1'b0;
        end else begin
            state    <= state_d;
            residual <= residual_d;
            all_q    <= all_d;
        end
    end

endmodule

// File: tb/tb_vector_scanner.sv
// Scoreboard bench for vector_scanner: the driver pushes expected beats from a
// set-bit enumeration model, the monitor compares every valid output cycle.
module tb_vector_scanner;

    localparam int WIDTH = 32;
    localparam int POS_W = 6;

    typedef struct {
        int pos;
        bit last;
        bit none;
    } beat_t;

    logic clk;
    logic rst_n;

    vector_scanner_if #(.WIDTH(WIDTH)) vif ();

    vector_scanner #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t exp_q [$];
    int    checks     = 0;
    int    failures   = 0;
    int    beats_seen = 0;
    int    ready_mode = 1;  // 0 random, 1 high, 2 low

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: list set bits in scan order, positions measured from the
    // scan start; zero vectors yield a single NONE beat.
    task automatic push_expected(input logic [WIDTH-1:0] d, input bit dir, input bit all);
        int    hits [$];
        int    n;
        beat_t b;
        for (int p = 0; p < WIDTH; p++) begin
            if (dir == 1'b0) begin
                if (d[WIDTH-1-p]) hits.push_back(p);
            end else begin
                if (d[p]) hits.push_back(p);
            end
        end
        if (hits.size() == 0) begin
            b.pos = WIDTH; b.last = 1'b1; b.none = 1'b1;
            exp_q.push_back(b);
        end else begin
            n = all ? hits.size() : 1;
            for (int k = 0; k < n; k++) begin
                b.pos = hits[k]; b.last = (k == n - 1); b.none = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit dir, input bit all,
                        output bit first_try);
        int tries = 0;
        bit acc   = 1'b0;
        first_try = 1'b0;
        while (!acc) begin
            @(negedge clk);
            vif.in_valid = 1'b1;
            vif.data_in  = d;
            vif.dir_in   = dir;
            vif.all_in   = all;
            #1;
            acc = vif.in_ready;
            if (acc && tries == 0) first_try = 1'b1;
            @(posedge clk);
            if (acc) begin
                push_expected(d, dir, all);
                #1 vif.in_valid = 1'b0;
            end
            tries++;
            if (!acc && tries > 500) begin
                check_eq("accept_timeout", 0, 1);
                vif.in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || vif.out_valid) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check_eq({name, "_drain_timeout"}, (cyc < 3000) ? 1 : 0, 1);
    endtask

    task automatic wait_beats(input int target, input string name);
        int cyc = 0;
        while (beats_seen < target && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        check_eq({name, "_beat_timeout"}, (cyc < 1000) ? 1 : 0, 1);
    endtask

    // Monitor: out_ready chosen at negedge, outputs sampled 1 time unit later.
    initial begin
        beat_t e;
        vif.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       vif.out_ready = ($urandom_range(0, 9) < 7);
                1:       vif.out_ready = 1'b1;
                default: vif.out_ready = 1'b0;
            endcase
            #1;
            if (rst_n && vif.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    check_eq("pos_out",  vif.pos_out,  e.pos);
                    check_eq("last_out", vif.last_out, e.last);
                    check_eq("none_out", vif.none_out, e.none);
                    if (vif.out_ready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit               ft;
        int               base;
        int               all_first;
        logic [WIDTH-1:0] d;

        vif.in_valid = 1'b0;
        vif.data_in  = '0;
        vif.dir_in   = 1'b0;
        vif.all_in   = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", vif.out_valid, 0);
        check_eq("rst_pos_out",   vif.pos_out,   0);
        check_eq("rst_last_out",  vif.last_out,  0);
        check_eq("rst_none_out",  vif.none_out,  0);
        check_eq("rst_in_ready",  vif.in_ready,  1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        ready_mode = 1;
        send(32'h8000_0001, 1'b0, 1'b0, ft);
        send(32'h8000_0001, 1'b0, 1'b1, ft);
        send(32'h0000_0000, 1'b0, 1'b0, ft);
        send(32'h0000_0000, 1'b1, 1'b1, ft);
        send(32'h0000_0012, 1'b1, 1'b1, ft);
        wait_drain("directed");

        // Backpressure mid-stream: pos 1 must hold while stalled
        base = beats_seen;
        send(32'hF000_0000, 1'b0, 1'b1, ft);
        wait_beats(base + 1, "bp");
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1 check_eq("bp_stall_valid", vif.out_valid, 1);
        check_eq("bp_stall_pos", vif.pos_out, 1);
        ready_mode = 1;
        wait_drain("bp");

        // Back-to-back first-hit vectors: each must be accepted immediately
        all_first = 0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom() | 32'h1;
            send(d, i[0], 1'b0, ft);
            all_first += ft;
        end
        check_eq("b2b_first_try", all_first, 8);
        wait_drain("b2b");

        // Reset mid-scan after 5 beats of an all-ones enumeration
        base = beats_seen;
        send(32'hFFFF_FFFF, 1'b0, 1'b1, ft);
        wait_beats(base + 5, "rst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", vif.out_valid, 0);
        check_eq("midrst_in_ready",  vif.in_ready,  1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h0000_0100, 1'b0, 1'b0, ft);
        wait_drain("post_rst");

        // Randomised traffic with random backpressure and gaps
        ready_mode = 0;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom();
                1:       d = $urandom() & $urandom() & $urandom();
                2:       d = '0;
                default: d = 32'h1 << $urandom_range(0, WIDTH - 1);
            endcase
            send(d, $urandom_range(0, 1), $urandom_range(0, 1), ft);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        ready_mode = 1;
        wait_drain("random");
        check_eq("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_scanner.md
# vector_scanner

Parametrised, handshaked successor to the combinational leading-one detector. It accepts one WIDTH-bit vector per transaction and emits the positions of its set bits one beat at a time, in priority order. Two modes: first-hit only, or enumerate all hits. The scan can start from the MSB or the LSB. Sits between a request-mask producer (arbiters, free-list bitmaps) and any consumer that takes one index per cycle.

## Interface
- WIDTH, 32, vector width; any value ≥ 2.
- POS_W, derived as $clog2(WIDTH)+1, not overridable; wide enough to encode the value WIDTH.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  vector offered.
- in_ready  output  1  scanner can accept a vector this cycle.
- data_in  input  WIDTH  vector to scan.
- dir_in  input  1  scan direction: 0 = MSB-first, 1 = LSB-first; sampled at accept.
- all_in  input  1  mode: 0 = first hit only, 1 = enumerate all hits; sampled at accept.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the beat.
- pos_out  output  POS_W  hit position measured from the scan start.
- last_out  output  1  final beat of the current vector.
- none_out  output  1  vector contained no set bit.

## Operation
- States: IDLE and SCAN. Registers: state, residual[WIDTH-1:0], all_q.
- Accept happens when in_valid && in_ready.
  - residual is loaded with data_in, bit-reversed when dir_in=1, so the core always scans MSB-first.
  - all_q is loaded from all_in. The next state is SCAN.
- In SCAN, out_valid=1.
- pos_out = leading-one index of residual, where residual[WIDTH-1] gives 0.
  - With dir_in=0, position p means bit WIDTH-1-p. This is the legacy encoding: bit 31 gives 0 and bit 0 gives 31.
  - With dir_in=1, position p means bit p.
- Zero vector: pos_out=WIDTH, none_out=1, last_out=1. This is a single beat in either mode.
- last_out = !all_q || (residual has exactly one set bit) || (residual == 0).
- Beat handshake (out_valid && out_ready):
  - If last_out is 1: go to IDLE, or reload immediately if a new accept happens in the same cycle.
  - Otherwise: clear the reported bit in residual and stay in SCAN.
- in_ready = (state==IDLE) || (out_valid && out_ready && last_out). This gives back-to-back vectors with no bubble.
- While out_valid=0, pos_out, last_out and none_out are driven to 0.
- Outputs are combinational from registers only. There is no path from data_in, dir_in or all_in to the result outputs.
- in_ready depends combinationally on out_ready. This is the only input-to-output path.

## Timing
- Reset (async assert, held while rst_n=0):
  - state=IDLE, residual=0.
  - out_valid=0, pos_out=0, last_out=0, none_out=0.
  - in_ready=1.
- Latency: a vector accepted on edge N presents its first beat from edge N (out_valid high in cycle N+1).
- Throughput:
  - first-hit mode: 1 vector/cycle with out_ready held high;
  - all mode: 1 hit/cycle; k hits take k cycles.
- Backpressure: while out_valid && !out_ready, pos_out, last_out, none_out and residual stay stable.
- Simultaneous final-beat handshake and new accept: the new vector replaces residual on the same edge, and no bubble is inserted.
- Reset mid-scan: the scan aborts and the remaining hits are discarded. The first vector after rst_n release is scanned correctly.
- WIDTH not a power of two: the encoder pads internally with zeros below the LSB. The padding never produces a hit.

## Structure
- Package vector_detector_pkg holds:
  - the state enum (IDLE, SCAN);
  - a pos_width(WIDTH) constant function;
  - the NONE encoding, which equals WIDTH.
- Sub-module lead_one_enc (parameter WIDTH) is a combinational log2-depth binary-tree leading-one encoder.
  - Outputs: position and any.
  - It is the generalised replacement for the hand-unrolled 32-bit mux tree.
  - It is reused by other blocks.
- vector_scanner instantiates one lead_one_enc on residual and adds the reversal, the clear-bit mask (one-hot decode of pos) and the single-bit test residual & (residual-1) == 0.

## Test plan
- WIDTH=32, 0x8000_0001, dir=0, all=0 → one beat: pos=0, last=1, none=0.
- Same vector with all=1 → beat 1: pos=0, last=0; beat 2: pos=31, last=1.
- 0x0000_0000 with any mode → one beat: pos=32, none=1, last=1.
- dir=1, all=1, 0x0000_0012 → beat 1: pos=1, last=0; beat 2: pos=4, last=1.
- Backpressure and back-to-back:
  - all=1 on 0xF000_0000 with out_ready low for 3 cycles mid-stream → outputs frozen, then pos 1, 2, 3 follow, with last on pos 3.
  - first-hit mode with in_valid and out_ready held high → one result per cycle with no bubbles.
- rst_n pulsed low after 5 beats of 0xFFFF_FFFF (all=1):
  - out_valid drops at once, in_ready=1;
  - then 0x0000_0100 (dir=0) → pos=23, last=1.
